coin_feeder: RTL and testbench

COIN_FEEDER -- requirements
Module: coin_feeder

---
 rtl/coin_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_coin_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_feeder.sv
// coin_feeder: pays for a vending transaction by feeding a sequence of
// 10-unit and 5-unit coins onto a registered coin bus, one coin per pulse,
// with GAP idle cycles after every coin, and counts the vending machine's
// dispense / change-5 responses.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle transaction request, honoured only in IDLE
//   num10        number of 10-unit coins (sampled on accepted start)
//   num5         number of 5-unit coins (sampled on accepted start)
//   fives_first  0: all 10s then 5s, 1: all 5s then 10s
//   dispense     vending machine response, valid in the coin cycle
//   chg5         vending machine change-5 response, valid in the coin cycle
//   coin         2'b01 = 5, 2'b10 = 10, 2'b00 = none (2'b11 never driven)
//   busy         high from the cycle after accepted start through done
//   done         one-cycle pulse at transaction end
//   items        dispense responses seen in the current/last transaction
//   change5      chg5 responses seen in the current/last transaction
//   dbg_state    current FSM state (0 IDLE, 1 DRIVE, 2 GAP, 3 DONE)
//
// Handshake: there is no backpressure. A start pulse is accepted on a rising
// edge only while the FSM is IDLE; a start seen in any other state is dropped.
// dispense/chg5 are Mealy responses to the coin on the bus and are counted at
// the edge that ends any non-IDLE cycle.
//
// GAP must be in 1..7 (the gap counter is 3 bits wide).

module coin_feeder #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] num10,
  input  logic [3:0] num5,
  input  logic       fives_first,
  input  logic       dispense,
  input  logic       chg5,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic [3:0] items,
  output logic [3:0] change5,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [2:0] GAP_LAST  = 3'(GAP - 1);

  state_t     state_q,   state_d;
  logic [2:0] n10_q,     n10_d;
  logic [3:0] n5_q,      n5_d;
  logic       ff_q,      ff_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic [1:0] coin_q,    coin_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic [3:0] items_q,   items_d;
  logic [3:0] change5_q, change5_d;

  // Coin selection works from the live inputs when launching the first coin
  // out of IDLE, and from the latched remaining counts otherwise.
  logic [2:0] src_n10;
  logic [3:0] src_n5;
  logic       src_ff;
  logic       pick_ten;
  logic [1:0] next_coin;
  logic [2:0] next_n10;
  logic [3:0] next_n5;

  always_comb begin
    src_n10 = (state_q == ST_IDLE) ? num10       : n10_q;
    src_n5  = (state_q == ST_IDLE) ? num5        : n5_q;
    src_ff  = (state_q == ST_IDLE) ? fives_first : ff_q;
    // When the preferred type is exhausted, fall through to the other one
    // directly so no extra gap is inserted at the switch-over.
    pick_ten  = src_ff ? (src_n5 == 4'd0) : (src_n10 != 3'd0);
    next_coin = pick_ten ? COIN_10 : COIN_5;
    next_n10  = pick_ten ? (src_n10 - 3'd1) : src_n10;
    next_n5   = pick_ten ? src_n5 : (src_n5 - 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    n10_d     = n10_q;
    n5_d      = n5_q;
    ff_d      = ff_q;
    gap_cnt_d = gap_cnt_q;
    coin_d    = COIN_NONE;
    items_d   = items_q;
    change5_d = change5_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ff_d      = fives_first;
          items_d   = 4'd0;
          change5_d = 4'd0;
          if (num10 == 3'd0 && num5 == 4'd0) begin
            n10_d   = 3'd0;
            n5_d    = 4'd0;
            state_d = ST_DONE;
          end else begin
            // coin is registered, so the first coin is loaded here to
            // appear on the bus in the cycle right after start.
            n10_d   = next_n10;
            n5_d    = next_n5;
            coin_d  = next_coin;
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DRIVE: begin
        gap_cnt_d = 3'd0;
        state_d   = ST_GAP;
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (n10_q != 3'd0 || n5_q != 4'd0) begin
            n10_d   = next_n10;
            n5_d    = next_n5;
            coin_d  = next_coin;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Responses count in every non-IDLE state, saturating at 15.
    if (state_q != ST_IDLE) begin
      if (dispense && items_q != 4'hf) begin
        items_d = items_q + 4'd1;
      end
      if (chg5 && change5_q != 4'hf) begin
        change5_d = change5_q + 4'd1;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      n10_q     <= 3'd0;
      n5_q      <= 4'd0;
      ff_q      <= 1'b0;
      gap_cnt_q <= 3'd0;
      coin_q    <= COIN_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      items_q   <= 4'd0;
      change5_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      n10_q     <= n10_d;
      n5_q      <= n5_d;
      ff_q      <= ff_d;
      gap_cnt_q <= gap_cnt_d;
      coin_q    <= coin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      items_q   <= items_d;
      change5_q <= change5_d;
    end
  end

  assign coin      = coin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign items     = items_q;
  assign change5   = change5_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: two instances (GAP=1 and GAP=3), each paired with a
// price-20 Mealy vending machine model. Per-cycle expectations of
// {busy, done, coin} are queued when a transaction is launched and popped
// as each cycle is sampled on the falling edge.

module tb_coin_feeder;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [2:0] num10;
  logic [3:0] num5;
  logic       fives_first;

  logic       disp_a, chg_a, disp_b, chg_b;
  logic [1:0] coin_a, coin_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [3:0] items_a, items_b, change5_a, change5_b;
  logic [1:0] dbg_a, dbg_b;
  logic [4:0] credit_a, credit_b, ncr_a, ncr_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  int model_cr[2];

  coin_feeder #(.GAP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .num10(num10), .num5(num5),
    .fives_first(fives_first), .dispense(disp_a), .chg5(chg_a),
    .coin(coin_a), .busy(busy_a), .done(done_a), .items(items_a),
    .change5(change5_a), .dbg_state(dbg_a)
  );

  coin_feeder #(.GAP(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num10(num10), .num5(num5),
    .fives_first(fives_first), .dispense(disp_b), .chg5(chg_b),
    .coin(coin_b), .busy(busy_b), .done(done_b), .items(items_b),
    .change5(change5_b), .dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- price-20 Mealy vending machines ----------------
  // Returns {dispense, chg5, next_credit}.
  function automatic logic [6:0] vend(input logic [4:0] cr, input logic [1:0] c);
    logic [4:0] val;
    logic [4:0] sum;
    val = (c == 2'b01) ? 5'd5 : (c == 2'b10) ? 5'd10 : 5'd0;
    sum = cr + val;
    if (c != 2'b00 && sum >= 5'd20) return {1'b1, (sum == 5'd25), 5'd0};
    return {1'b0, 1'b0, sum};
  endfunction

  always_comb {disp_a, chg_a, ncr_a} = vend(credit_a, coin_a);
  always_comb {disp_b, chg_b, ncr_b} = vend(credit_b, coin_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_a <= 5'd0;
      credit_b <= 5'd0;
    end else begin
      credit_a <= ncr_a;
      credit_b <= ncr_b;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + scoreboard ----------------
  // Launches a transaction on instance `which` (0: GAP=1, 1: GAP=3) at the
  // current falling edge. rep>0 re-pulses start (with different operands)
  // in that cycle of the transaction, which must be ignored.
  task automatic run_txn(input string tag, input int which, input int n10,
                         input int n5, input bit ff, input int rep);
    int gap;
    int cr;
    int it;
    int ch;
    int ntr;
    int val;
    logic [1:0] coins[$];
    logic [3:0] obs;
    logic [3:0] exp;

    gap = (which == 1) ? 3 : 1;
    if (ff) begin
      repeat (n5) coins.push_back(2'b01);
      repeat (n10) coins.push_back(2'b10);
    end else begin
      repeat (n10) coins.push_back(2'b10);
      repeat (n5) coins.push_back(2'b01);
    end

    cr = model_cr[which];
    it = 0;
    ch = 0;
    foreach (coins[i]) begin
      exp_q.push_back({1'b1, 1'b0, coins[i]});
      repeat (gap) exp_q.push_back(4'b1000);
      val = (coins[i] == 2'b10) ? 10 : 5;
      if (cr + val >= 20) begin
        if (it < 15) it++;
        if (cr + val == 25 && ch < 15) ch++;
        cr = 0;
      end else begin
        cr = cr + val;
      end
    end
    exp_q.push_back(4'b1100);  // done cycle
    exp_q.push_back(4'b0000);  // back in IDLE
    model_cr[which] = cr;

    num10 = 3'(n10);
    num5 = 4'(n5);
    fives_first = ff;
    if (which == 1) start_b = 1'b1;
    else start_a = 1'b1;

    ntr = exp_q.size();
    for (int c = 1; c <= ntr; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (c == rep) begin
        num10 = 3'd7;
        num5 = 4'd9;
        fives_first = ~ff;
        if (which == 1) start_b = 1'b1;
        else start_a = 1'b1;
      end
      obs = (which == 1) ? {busy_b, done_b, coin_b} : {busy_a, done_a, coin_a};
      exp = exp_q.pop_front();
      check($sformatf("%s cyc%0d busy/done/coin", tag, c), 32'(obs), 32'(exp));
    end
    start_a = 1'b0;
    start_b = 1'b0;

    check({tag, " items"}, (which == 1) ? 32'(items_b) : 32'(items_a), 32'(it));
    check({tag, " change5"}, (which == 1) ? 32'(change5_b) : 32'(change5_a), 32'(ch));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    num10 = 3'd0;
    num5 = 4'd0;
    fives_first = 1'b0;
    model_cr[0] = 0;
    model_cr[1] = 0;

    repeat (2) @(negedge clk);
    check("reset coin_a", 32'(coin_a), 32'd0);
    check("reset busy_a", 32'(busy_a), 32'd0);
    check("reset done_a", 32'(done_a), 32'd0);
    check("reset items_a", 32'(items_a), 32'd0);
    check("reset change5_a", 32'(change5_a), 32'd0);
    check("reset state_a", 32'(dbg_a), 32'd0);
    check("reset coin_b", 32'(coin_b), 32'd0);
    rst = 1'b1;

    // Order: 10, 5, 5 -> done at cycle 7, one item, no change.
    run_txn("order", 0, 1, 2, 1'b0, 0);
    check("order items const", 32'(items_a), 32'd1);
    // Change: 5, 10, 10 -> 25 on the third coin.
    run_txn("change", 0, 2, 1, 1'b1, 0);
    check("change change5 const", 32'(change5_a), 32'd1);
    // Zero: done in the cycle after start, no coin.
    run_txn("zero", 0, 0, 0, 1'b0, 0);
    // Ignore: start re-pulsed in cycle 2 while busy.
    run_txn("ignore", 0, 4, 0, 1'b0, 2);
    check("ignore items const", 32'(items_a), 32'd2);
    // One 10 leaves 10 credit so the next transaction dispenses on coin 1.
    run_txn("single10", 0, 1, 0, 1'b0, 0);

    // Reset during the second DRIVE of a 10,10,10 transaction.
    num10 = 3'd3;
    num5 = 4'd0;
    fives_first = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("rst pre cyc1 coin", 32'(coin_a), 32'h2);
    @(negedge clk);
    @(negedge clk);
    check("rst pre cyc3 coin", 32'(coin_a), 32'h2);
    check("rst pre cyc3 items", 32'(items_a), 32'd1);
    check("rst pre cyc3 state", 32'(dbg_a), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst async coin", 32'(coin_a), 32'd0);
    check("rst async busy", 32'(busy_a), 32'd0);
    check("rst async items", 32'(items_a), 32'd0);
    check("rst async change5", 32'(change5_a), 32'd0);
    check("rst async state", 32'(dbg_a), 32'd0);
    model_cr[0] = 0;
    model_cr[1] = 0;
    @(negedge clk);
    check("rst hold done", 32'(done_a), 32'd0);
    @(negedge clk);
    check("rst hold done2", 32'(done_a), 32'd0);
    rst = 1'b1;
    // Start on the very first edge after release.
    run_txn("post_rst", 0, 1, 2, 1'b1, 0);

    // Gap: GAP=3, four 5s -> pulses 4 cycles apart, done at cycle 17.
    run_txn("gap3", 1, 0, 4, 1'b0, 0);
    check("gap3 items const", 32'(items_b), 32'd1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
